tt_mux_ctrl_seq: RTL and testbench

Sequencer that drives the three-wire design-select control interface of the TinyTapeout mux: `ctrl_sel_rst_n`, `ctrl_sel_inc` and `ctrl_ena`. A single request carries a design address. The block then generates the disable, select-reset, increment and enable waveforms that the mux expects. It sits between the management-side controller (or a bench) and the mux control pins. It generalises direct pin-wiggling with these additions:

- parametrised address width and pulse timing;
- incremental (forward-only) reselection that skips the reset phase;
- a valid/ready request handshake.

---
 rtl/tt_mux_pkg.sv | 20 ++
 rtl/tt_phase_timer.sv | 32 +++
 rtl/tt_mux_ctrl_seq.sv | 161 ++++++++++++++++
 tb/tb_tt_mux_ctrl_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mux_pkg.sv
// Shared types and defaults for the TinyTapeout mux control sequencer.
package tt_mux_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DISABLE = 3'd1,
    S_RESET   = 3'd2,
    S_INC_HI  = 3'd3,
    S_INC_LO  = 3'd4,
    S_ENABLE  = 3'd5
  } seq_state_e;

  localparam int PULSE_CYCLES_DEF = 4;
  localparam int RST_CYCLES_DEF   = 8;

  function automatic int max_i(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tt_phase_timer.sv
// Loadable down-counter shared by every timed phase of the sequencer.
// Loading L-1 makes expire assert in the L-th cycle after the load edge.
module tt_phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expire
);

  logic [TW-1:0] cnt;
  logic          active;

  assign expire = active && (cnt == '0);

  // Count down while armed; disarm on expiry unless reloaded the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      active <= 1'b1;
    end else if (active) begin
      if (cnt == '0) active <= 1'b0;
      else           cnt    <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/tt_mux_ctrl_seq.sv
// Sequencer for the mux design-select pins (sel_rst_n / sel_inc / ena).
// Takes one addressed request at a time and walks disable, optional
// select-reset, N increment pulses, then re-enable with a done pulse.
module tt_mux_ctrl_seq
  import tt_mux_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int PULSE_CYCLES = PULSE_CYCLES_DEF,
  parameter int RST_CYCLES   = RST_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_ena,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              cur_valid,
  output logic              ctrl_sel_rst_n,
  output logic              ctrl_sel_inc,
  output logic              ctrl_ena
);

  localparam int TW = $clog2(max_i(PULSE_CYCLES, RST_CYCLES)) + 1;
  localparam logic [TW-1:0] P_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] R_LD = TW'(RST_CYCLES - 1);

  seq_state_e        state;
  logic [ADDR_W-1:0] n_cnt;
  logic              rst_path;
  logic              ena_q;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              expire;
  logic              accept;

  // The done cycle is already IDLE, so it is masked out of ready to give
  // back-to-back requests one idle cycle between sequences.
  assign req_ready = (state == S_IDLE) && !done;
  assign busy      = (state != S_IDLE);
  assign accept    = req_valid && req_ready;

  // Arm the phase timer on the same edge that enters each timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = P_LD;
    case (state)
      S_IDLE:    tmr_load = accept;
      S_DISABLE: begin
        if (expire) begin
          if (rst_path) begin
            tmr_load = 1'b1;
            tmr_val  = R_LD;
          end else begin
            tmr_load = (n_cnt != '0);
          end
        end
      end
      S_RESET:   tmr_load = expire && (n_cnt != '0);
      S_INC_HI:  tmr_load = expire;
      S_INC_LO:  tmr_load = expire && (n_cnt != ADDR_W'(1));
      default:   tmr_load = 1'b0;
    endcase
  end

  tt_phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (expire)
  );

  // Sequencer FSM with registered pin outputs and tracked mux address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_IDLE;
      n_cnt          <= '0;
      rst_path       <= 1'b0;
      ena_q          <= 1'b0;
      done           <= 1'b0;
      cur_addr       <= '0;
      cur_valid      <= 1'b0;
      ctrl_sel_rst_n <= 1'b0;
      ctrl_sel_inc   <= 1'b0;
      ctrl_ena       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            ena_q    <= req_ena;
            ctrl_ena <= 1'b0;
            state    <= S_DISABLE;
            // Forward-only moves from a known address skip the select-reset.
            if (cur_valid && (req_addr >= cur_addr)) begin
              rst_path <= 1'b0;
              n_cnt    <= req_addr - cur_addr;
            end else begin
              rst_path <= 1'b1;
              n_cnt    <= req_addr;
            end
          end
        end
        S_DISABLE: begin
          if (expire) begin
            if (rst_path) begin
              ctrl_sel_rst_n <= 1'b0;
              state          <= S_RESET;
            end else if (n_cnt != '0) begin
              ctrl_sel_inc <= 1'b1;
              state        <= S_INC_HI;
            end else begin
              state <= S_ENABLE;
            end
          end
        end
        S_RESET: begin
          if (expire) begin
            ctrl_sel_rst_n <= 1'b1;
            cur_addr       <= '0;
            cur_valid      <= 1'b1;
            if (n_cnt != '0) begin
              ctrl_sel_inc <= 1'b1;
              state        <= S_INC_HI;
            end else begin
              state <= S_ENABLE;
            end
          end
        end
        S_INC_HI: begin
          if (expire) begin
            ctrl_sel_inc <= 1'b0;
            state        <= S_INC_LO;
          end
        end
        S_INC_LO: begin
          if (expire) begin
            cur_addr <= cur_addr + ADDR_W'(1);
            n_cnt    <= n_cnt - ADDR_W'(1);
            if (n_cnt != ADDR_W'(1)) begin
              ctrl_sel_inc <= 1'b1;
              state        <= S_INC_HI;
            end else begin
              state <= S_ENABLE;
            end
          end
        end
        S_ENABLE: begin
          ctrl_ena <= ena_q;
          done     <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_mux_ctrl_seq.sv
// Bench for tt_mux_ctrl_seq: a waveform model predicts every output on every
// cycle, and directed requests pin latency, pulse counts and final address.
module tb_tt_mux_ctrl_seq;

  localparam int P = 2;
  localparam int R = 3;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_addr;
  logic       req_ena;
  logic       busy;
  logic       done;
  logic [9:0] cur_addr;
  logic       cur_valid;
  logic       ctrl_sel_rst_n;
  logic       ctrl_sel_inc;
  logic       ctrl_ena;

  int checks = 0;
  int errors = 0;
  bit run    = 1'b0;

  always #5 clk = ~clk;

  tt_mux_ctrl_seq #(.ADDR_W(10), .PULSE_CYCLES(P), .RST_CYCLES(R)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_addr       (req_addr),
    .req_ena        (req_ena),
    .busy           (busy),
    .done           (done),
    .cur_addr       (cur_addr),
    .cur_valid      (cur_valid),
    .ctrl_sel_rst_n (ctrl_sel_rst_n),
    .ctrl_sel_inc   (ctrl_sel_inc),
    .ctrl_ena       (ctrl_ena)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Observed output bundle, one entry per cycle.
  typedef struct packed {
    logic       rn;
    logic       inc;
    logic       ena;
    logic       dn;
    logic       bsy;
    logic       rdy;
    logic       vld;
    logic [9:0] addr;
  } obs_t;

  obs_t       q[$];
  logic       m_rn, m_ena, m_vld;
  logic [9:0] m_addr;

  // Expand one accepted request into its expected per-cycle waveform.
  task automatic build(input logic [9:0] a, input logic en);
    logic       rn, v;
    logic [9:0] cur;
    int         n;
    bit         rp;
    rn  = m_rn;
    v   = m_vld;
    cur = m_addr;
    rp  = !(m_vld && (a >= m_addr));
    n   = rp ? int'(a) : int'(a - m_addr);
    repeat (P) q.push_back({rn, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v, cur});
    if (rp) begin
      repeat (R) q.push_back({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v, cur});
      rn = 1'b1; v = 1'b1; cur = '0;
    end
    for (int i = 0; i < n; i++) begin
      repeat (P) q.push_back({rn, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, v, cur});
      repeat (P) q.push_back({rn, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v, cur});
      cur = cur + 10'd1;
    end
    q.push_back({rn, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, v, cur});
    q.push_back({rn, 1'b0, en,   1'b1, 1'b0, 1'b0, v, cur});
    m_rn = rn; m_ena = en; m_vld = v; m_addr = cur;
  endtask

  // Cycle-by-cycle comparison against the model, sampled on the falling edge.
  initial begin
    obs_t e, a;
    m_rn = 1'b0; m_ena = 1'b0; m_vld = 1'b0; m_addr = '0;
    forever begin
      @(negedge clk);
      if (run) begin
        a = {ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, done, busy, req_ready, cur_valid, cur_addr};
        if (!reset_n) begin
          q.delete();
          m_rn = 1'b0; m_ena = 1'b0; m_vld = 1'b0; m_addr = '0;
          e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd0};
        end else if (q.size() > 0) begin
          e = q.pop_front();
        end else begin
          e = {m_rn, 1'b0, m_ena, 1'b0, 1'b0, 1'b1, m_vld, m_addr};
        end
        chk("cycle", 32'(a), 32'(e));
        if (reset_n && e.rdy && req_valid) build(req_addr, req_ena);
      end
    end
  end

  // One request from idle; measures latency, rising inc edges, sel_rst_n low cycles.
  task automatic do_req(input logic [9:0] a, input logic en, input int e_lat, input int e_inc,
                        input int e_rl, input logic [9:0] e_addr, input string nm);
    int   lat, incs, rl;
    logic pinc;
    lat = 999; incs = 0; rl = 0; pinc = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_ena = en;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (c != 0 || 1'b1) @(negedge clk);
      if (!ctrl_sel_rst_n) rl++;
      if (ctrl_sel_inc && !pinc) incs++;
      pinc = ctrl_sel_inc;
      if (done) begin
        lat = c;
        break;
      end
    end
    chk({nm, "_lat"},  32'(lat),      32'(e_lat));
    chk({nm, "_incs"}, 32'(incs),     32'(e_inc));
    chk({nm, "_rstlo"}, 32'(rl),      32'(e_rl));
    chk({nm, "_addr"}, 32'(cur_addr), 32'(e_addr));
    chk({nm, "_ena"},  32'(ctrl_ena), 32'(en));
  endtask

  initial begin
    int  lat, viol;
    bit  ok;
    int  exp_lat [4] = '{7, 11, 14, 11};
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_ena = 1'b0;
    run = 1'b1;
    #1;
    chk("rst_ctrl",  32'({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena}), 32'd0);
    chk("rst_cur",   32'({cur_valid, cur_addr}), 32'd0);
    chk("rst_flags", 32'({busy, done, req_ready}), 32'b001);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // addr, ena, latency, incs, sel_rst_n low cycles (incl. DISABLE when still low), final addr
    do_req(10'd5, 1'b1, 26, 5, 5, 10'd5, "r5");
    do_req(10'd7, 1'b1, 11, 2, 0, 10'd7, "i7");
    do_req(10'd3, 1'b1, 18, 3, 3, 10'd3, "b3");
    do_req(10'd3, 1'b0,  3, 0, 0, 10'd3, "s3");
    do_req(10'd0, 1'b1,  6, 0, 3, 10'd0, "z0");

    // Asynchronous reset in the middle of an INC_HI phase.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 10'd9; req_ena = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (ctrl_sel_inc) begin
        ok = 1'b1;
        break;
      end
    end
    chk("a9_inc_seen", 32'(ok), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_ctrl",  32'({ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena}), 32'd0);
    chk("ar_cur",   32'({cur_valid, cur_addr}), 32'd0);
    chk("ar_flags", 32'({busy, done}), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    do_req(10'd1, 1'b1, 10, 1, 5, 10'd1, "p1");

    // Held req_valid, alternating 2/4: accepted once per sequence after done.
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 10'd2; req_ena = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (req_ready) begin
          ok = 1'b1;
          break;
        end
      end
      chk("bb_accept", 32'(ok), 32'd1);
      @(posedge clk); #1;
      req_addr = (k % 2 == 0) ? 10'd4 : 10'd2;
      if (k == 3) req_valid = 1'b0;
      lat = 999; viol = 0;
      for (int c = 0; c < 60; c++) begin
        @(negedge clk);
        if (req_ready) viol++;
        if (done) begin
          lat = c;
          break;
        end
      end
      chk("bb_lat", 32'(lat), 32'(exp_lat[k]));
      chk("bb_ready_low", 32'(viol), 32'd0);
    end
    chk("bb_final_addr", 32'(cur_addr), 32'd4);

    repeat (4) @(posedge clk);
    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
